// File: rtl/packet_disassembler_if.sv
// rtl/packet_disassembler_if.sv - data island packet beat input and decoded packet output bundle
interface packet_disassembler_if;
   logic        enable;
   logic        packet_start;
   logic [8:0]  packet_data;
   logic [23:0] header;
   logic [55:0] sub [3:0];
   logic        packet_valid;
   logic [4:0]  ecc_error;
   logic [4:0]  ecc_corrected;
   logic        framing_error;

   modport master (
      output enable, packet_start, packet_data,
      input  header, sub, packet_valid, ecc_error, ecc_corrected, framing_error
   );

   modport slave (
      input  enable, packet_start, packet_data,
      output header, sub, packet_valid, ecc_error, ecc_corrected, framing_error
   );
endinterface

// File: rtl/packet_disassembler.sv
// rtl/packet_disassembler.sv - rebuilds 32-beat data island packets and checks the five BCH blocks
// Optional single-bit correction stage: PACKET_ECC_CORRECT_EN
module packet_disassembler (
   input  logic                  i_clk_pixel,
   input  logic                  i_reset,
   packet_disassembler_if.slave  pkt
);
   typedef enum logic {IDLE, COLLECT} state_t;

   state_t      r_state, w_state_next;
   logic [4:0]  r_k, w_k_next;
   logic        w_capture, w_first, w_done, w_frame;
   logic [4:0]  w_beat;

   logic [31:0] r_hdr_cw, w_hdr_cw;
   logic [63:0] r_sub_cw [3:0];
   logic [63:0] w_sub_cw [3:0];
   logic [7:0]  r_ecc_hdr, w_ecc_hdr;
   logic [7:0]  r_ecc_sub [3:0];
   logic [7:0]  w_ecc_sub [3:0];
   logic [7:0]  w_syn_hdr;
   logic [7:0]  w_syn_sub [3:0];

   logic        r_valid;
   logic        r_framing;
   logic [23:0] r_header;
   logic [55:0] r_sub [3:0];
   logic [4:0]  r_ecc_error;

   function automatic logic [7:0] f_ecc_step(input logic [7:0] e, input logic b);
      f_ecc_step = (e >> 1) ^ ((e[0] ^ b) ? 8'b1000_0011 : 8'h00);
   endfunction

   always_ff @(posedge i_clk_pixel or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_k     <= 5'd0;
      end else begin
         r_state <= w_state_next;
         r_k     <= w_k_next;
      end
   end

   // A start beat always opens a fresh packet, aborting any partial one in progress
   always_comb begin
      w_state_next = r_state;
      w_k_next     = r_k;
      w_capture    = 1'b0;
      w_first      = 1'b0;
      w_done       = 1'b0;
      w_frame      = 1'b0;
      case (r_state)
         IDLE: begin
            if (pkt.enable && pkt.packet_start) begin
               w_capture    = 1'b1;
               w_first      = 1'b1;
               w_k_next     = 5'd1;
               w_state_next = COLLECT;
            end
         end
         COLLECT: begin
            if (!pkt.enable) begin
               w_frame      = 1'b1;
               w_k_next     = 5'd0;
               w_state_next = IDLE;
            end else if (pkt.packet_start) begin
               w_frame      = 1'b1;
               w_capture    = 1'b1;
               w_first      = 1'b1;
               w_k_next     = 5'd1;
            end else begin
               w_capture = 1'b1;
               w_k_next  = r_k + 5'd1;
               if (r_k == 5'd31) begin
                  w_done       = 1'b1;
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_beat = w_first ? 5'd0 : r_k;

   // Codewords shift in from the top so the first wire bit lands at bit 0 after 32 beats
   always_comb begin
      w_hdr_cw  = {pkt.packet_data[0], r_hdr_cw[31:1]};
      w_ecc_hdr = w_first ? 8'h00 : r_ecc_hdr;
      if (w_beat < 5'd24)
         w_ecc_hdr = f_ecc_step(w_ecc_hdr, pkt.packet_data[0]);
      w_syn_hdr = w_ecc_hdr ^ w_hdr_cw[31:24];
      for (int i = 0; i < 4; i++) begin
         w_sub_cw[i]  = {pkt.packet_data[5+i], pkt.packet_data[1+i], r_sub_cw[i][63:2]};
         w_ecc_sub[i] = w_first ? 8'h00 : r_ecc_sub[i];
         if (w_beat < 5'd28)
            w_ecc_sub[i] = f_ecc_step(f_ecc_step(w_ecc_sub[i], pkt.packet_data[1+i]),
                                      pkt.packet_data[5+i]);
         w_syn_sub[i] = w_ecc_sub[i] ^ w_sub_cw[i][63:56];
      end
   end

   always_ff @(posedge i_clk_pixel or posedge i_reset) begin
      if (i_reset) begin
         r_hdr_cw  <= 32'd0;
         r_ecc_hdr <= 8'h00;
         for (int i = 0; i < 4; i++) begin
            r_sub_cw[i]  <= 64'd0;
            r_ecc_sub[i] <= 8'h00;
         end
      end else if (w_capture) begin
         r_hdr_cw  <= w_hdr_cw;
         r_ecc_hdr <= w_ecc_hdr;
         for (int i = 0; i < 4; i++) begin
            r_sub_cw[i]  <= w_sub_cw[i];
            r_ecc_sub[i] <= w_ecc_sub[i];
         end
      end
   end

`ifdef PACKET_ECC_CORRECT_EN
   logic        r_s1_valid;
   logic [31:0] r_s1_hdr;
   logic [63:0] r_s1_sub [3:0];
   logic [7:0]  r_s1_syn_hdr;
   logic [7:0]  r_s1_syn_sub [3:0];
   logic [31:0] w_fix_hdr;
   logic [63:0] w_fix_sub [3:0];
   logic        w_hit_hdr;
   logic [3:0]  w_hit_sub;
   logic [4:0]  r_ecc_corrected;

   // Syndrome produced by a lone error at codeword position j of a block with n data bits
   function automatic logic [7:0] f_pos_syn(input int j, input int n);
      logic [7:0] e;
      e = 8'h00;
      if (j >= n)
         e = 8'd1 << (j - n);
      else
         for (int b = 0; b < n; b++)
            e = f_ecc_step(e, b == j);
      f_pos_syn = e;
   endfunction

   always_ff @(posedge i_clk_pixel or posedge i_reset) begin
      if (i_reset) begin
         r_s1_valid   <= 1'b0;
         r_s1_hdr     <= 32'd0;
         r_s1_syn_hdr <= 8'h00;
         for (int i = 0; i < 4; i++) begin
            r_s1_sub[i]     <= 64'd0;
            r_s1_syn_sub[i] <= 8'h00;
         end
      end else begin
         r_s1_valid <= w_done;
         if (w_done) begin
            r_s1_hdr     <= w_hdr_cw;
            r_s1_syn_hdr <= w_syn_hdr;
            for (int i = 0; i < 4; i++) begin
               r_s1_sub[i]     <= w_sub_cw[i];
               r_s1_syn_sub[i] <= w_syn_sub[i];
            end
         end
      end
   end

   always_comb begin
      w_fix_hdr = r_s1_hdr;
      w_hit_hdr = 1'b0;
      for (int j = 0; j < 32; j++)
         if (r_s1_syn_hdr != 8'h00 && r_s1_syn_hdr == f_pos_syn(j, 24)) begin
            w_fix_hdr[j] = ~r_s1_hdr[j];
            w_hit_hdr    = 1'b1;
         end
      for (int i = 0; i < 4; i++) begin
         w_fix_sub[i] = r_s1_sub[i];
         w_hit_sub[i] = 1'b0;
         for (int j = 0; j < 64; j++)
            if (r_s1_syn_sub[i] != 8'h00 && r_s1_syn_sub[i] == f_pos_syn(j, 56)) begin
               w_fix_sub[i][j] = ~r_s1_sub[i][j];
               w_hit_sub[i]    = 1'b1;
            end
      end
   end

   always_ff @(posedge i_clk_pixel or posedge i_reset) begin
      if (i_reset) begin
         r_valid         <= 1'b0;
         r_framing       <= 1'b0;
         r_header        <= 24'd0;
         r_ecc_error     <= 5'd0;
         r_ecc_corrected <= 5'd0;
         for (int i = 0; i < 4; i++)
            r_sub[i] <= 56'd0;
      end else begin
         r_valid   <= r_s1_valid;
         r_framing <= w_frame;
         if (r_s1_valid) begin
            r_header <= w_fix_hdr[23:0];
            r_ecc_error[4]     <= (r_s1_syn_hdr != 8'h00) && !w_hit_hdr;
            r_ecc_corrected[4] <= w_hit_hdr;
            for (int i = 0; i < 4; i++) begin
               r_sub[i]           <= w_fix_sub[i][55:0];
               r_ecc_error[i]     <= (r_s1_syn_sub[i] != 8'h00) && !w_hit_sub[i];
               r_ecc_corrected[i] <= w_hit_sub[i];
            end
         end
      end
   end

   assign pkt.ecc_corrected = r_ecc_corrected;
`else
   always_ff @(posedge i_clk_pixel or posedge i_reset) begin
      if (i_reset) begin
         r_valid     <= 1'b0;
         r_framing   <= 1'b0;
         r_header    <= 24'd0;
         r_ecc_error <= 5'd0;
         for (int i = 0; i < 4; i++)
            r_sub[i] <= 56'd0;
      end else begin
         r_valid   <= w_done;
         r_framing <= w_frame;
         if (w_done) begin
            r_header       <= w_hdr_cw[23:0];
            r_ecc_error[4] <= |w_syn_hdr;
            for (int i = 0; i < 4; i++) begin
               r_sub[i]       <= w_sub_cw[i][55:0];
               r_ecc_error[i] <= |w_syn_sub[i];
            end
         end
      end
   end

   assign pkt.ecc_corrected = 5'd0;
`endif

   assign pkt.packet_valid  = r_valid;
   assign pkt.framing_error = r_framing;
   assign pkt.header        = r_header;
   assign pkt.ecc_error     = r_ecc_error;
   assign pkt.sub           = r_sub;
endmodule

// File: tb/tb_packet_disassembler.sv
// tb/tb_packet_disassembler.sv - directed self-checking bench for packet_disassembler
module tb_packet_disassembler;
`ifdef PACKET_ECC_CORRECT_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   packet_disassembler_if u_if();

   packet_disassembler u_dut (
      .i_clk_pixel (clk),
      .i_reset     (rst),
      .pkt         (u_if.slave)
   );

   typedef struct {
      int               cyc;
      logic [23:0]      h;
      logic [3:0][55:0] s;
      logic [4:0]       err;
      logic [4:0]       cor;
   } rec_t;

   rec_t             q[$];
   int               cyc = 0;
   int               fe_cnt = 0;
   int               errors = 0;
   int               checks = 0;
   int               last_cyc = 0;
   logic [31:0]      cw_hdr;
   logic [3:0][63:0] cw_sub;
   logic [23:0]      exp_h;
   logic [3:0][55:0] exp_s;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      rec_t r;
      if (u_if.packet_valid) begin
         r.cyc = cyc;
         r.h   = u_if.header;
         for (int i = 0; i < 4; i++) r.s[i] = u_if.sub[i];
         r.err = u_if.ecc_error;
         r.cor = u_if.ecc_corrected;
         q.push_back(r);
      end
      if (u_if.framing_error) fe_cnt++;
   end

   function automatic logic [7:0] tb_ecc(input logic [63:0] d, input int n);
      logic [7:0] e;
      logic       fb;
      e = 8'h00;
      for (int i = 0; i < n; i++) begin
         fb = e[0] ^ d[i];
         e  = e >> 1;
         if (fb) e = e ^ 8'h83;
      end
      return e;
   endfunction

   task automatic build(input logic [23:0] h, input logic [3:0][55:0] s);
      exp_h  = h;
      exp_s  = s;
      cw_hdr = {tb_ecc({40'd0, h}, 24), h};
      for (int i = 0; i < 4; i++) cw_sub[i] = {tb_ecc({8'd0, s[i]}, 56), s[i]};
   endtask

   task automatic send_beats(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         u_if.enable         = 1'b1;
         u_if.packet_start   = (k == 0);
         u_if.packet_data[0] = cw_hdr[k];
         for (int i = 0; i < 4; i++) begin
            u_if.packet_data[1+i] = cw_sub[i][2*k];
            u_if.packet_data[5+i] = cw_sub[i][2*k+1];
         end
         if (k == 31) last_cyc = cyc;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         u_if.enable       = 1'b0;
         u_if.packet_start = 1'b0;
         u_if.packet_data  = 9'd0;
      end
   endtask

   function automatic logic [3:0][55:0] rand_subs();
      logic [3:0][55:0] s;
      for (int i = 0; i < 4; i++) s[i] = {24'($urandom()), 32'($urandom())};
      return s;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      idle(3);
      checks++; if (u_if.packet_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", u_if.packet_valid); end
      checks++; if (u_if.framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing got %b want 0", u_if.framing_error); end
      checks++; if (u_if.header !== 24'd0) begin errors++; $display("FAIL reset_header got %h want 0", u_if.header); end
      checks++; if (u_if.ecc_error !== 5'd0 || u_if.ecc_corrected !== 5'd0) begin errors++; $display("FAIL reset_ecc got %b/%b want 0/0", u_if.ecc_error, u_if.ecc_corrected); end
      checks++; if ((u_if.sub[0] | u_if.sub[3]) !== 56'd0) begin errors++; $display("FAIL reset_sub got %h want 0", u_if.sub[0] | u_if.sub[3]); end
      @(negedge clk);
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_null();
      rec_t r;
      q.delete();
      build(24'd0, '0);
      send_beats(32);
      idle(4);
      checks++; if (q.size() != 1) begin errors++; $display("FAIL null_count got %0d want 1", q.size()); end
      if (q.size() >= 1) begin
         r = q[0];
         checks++; if (r.cyc != last_cyc + LAT) begin errors++; $display("FAIL null_latency got %0d want %0d", r.cyc - last_cyc, LAT); end
         checks++; if (r.h !== 24'd0 || r.s !== '0) begin errors++; $display("FAIL null_data got %h/%h want 0", r.h, r.s); end
         checks++; if (r.err !== 5'd0) begin errors++; $display("FAIL null_ecc got %b want 00000", r.err); end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0][55:0] es [3];
      int               lc [3];
      q.delete();
      for (int j = 0; j < 3; j++) begin
         build(24'h0D0282, rand_subs());
         es[j] = exp_s;
         send_beats(32);
         lc[j] = last_cyc;
      end
      idle(4);
      checks++; if (q.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", q.size()); end
      for (int j = 0; j < 3 && j < q.size(); j++) begin
         checks++; if (q[j].h !== 24'h0D0282) begin errors++; $display("FAIL b2b_header[%0d] got %h want 0d0282", j, q[j].h); end
         checks++; if (q[j].s !== es[j]) begin errors++; $display("FAIL b2b_sub[%0d] got %h want %h", j, q[j].s, es[j]); end
         checks++; if (q[j].err !== 5'd0) begin errors++; $display("FAIL b2b_ecc[%0d] got %b want 00000", j, q[j].err); end
         checks++; if (q[j].cyc != lc[j] + LAT) begin errors++; $display("FAIL b2b_timing[%0d] got %0d want %0d", j, q[j].cyc, lc[j] + LAT); end
      end
   endtask

   task automatic test_ecc_single();
      logic [23:0]      wh;
      logic [3:0][55:0] ws;
      logic [4:0]       werr, wcor;
      q.delete();
      build(24'h0D0282, {56'hA5A5A5A5A5A5A5, 56'h0123456789ABCD, 56'hFEDCBA98765432, 56'h00FF00FF00FF00});
      cw_hdr[5]     = ~cw_hdr[5];
      cw_sub[2][40] = ~cw_sub[2][40];
      wh = exp_h;
      ws = exp_s;
`ifdef PACKET_ECC_CORRECT_EN
      werr = 5'b00000;
      wcor = 5'b10100;
`else
      wh[5]     = ~wh[5];
      ws[2][40] = ~ws[2][40];
      werr = 5'b10100;
      wcor = 5'b00000;
`endif
      send_beats(32);
      idle(4);
      checks++; if (q.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", q.size()); end
      if (q.size() >= 1) begin
         checks++; if (q[0].err !== werr) begin errors++; $display("FAIL single_ecc_error got %b want %b", q[0].err, werr); end
         checks++; if (q[0].cor !== wcor) begin errors++; $display("FAIL single_ecc_corrected got %b want %b", q[0].cor, wcor); end
         checks++; if (q[0].h !== wh) begin errors++; $display("FAIL single_header got %h want %h", q[0].h, wh); end
         checks++; if (q[0].s !== ws) begin errors++; $display("FAIL single_sub got %h want %h", q[0].s, ws); end
      end
   endtask

   task automatic test_ecc_double();
      q.delete();
      build(24'h0D0282, {56'h11111111111111, 56'h22222222222222, 56'h33333333333333, 56'h44444444444444});
      cw_sub[0][3]  = ~cw_sub[0][3];
      cw_sub[0][17] = ~cw_sub[0][17];
      send_beats(32);
      idle(4);
      checks++; if (q.size() != 1) begin errors++; $display("FAIL double_count got %0d want 1", q.size()); end
      if (q.size() >= 1) begin
         checks++; if (q[0].err !== 5'b00001) begin errors++; $display("FAIL double_ecc_error got %b want 00001", q[0].err); end
         checks++; if (q[0].cor !== 5'b00000) begin errors++; $display("FAIL double_ecc_corrected got %b want 00000", q[0].cor); end
      end
   endtask

   task automatic test_framing();
      int fe0;
      fe0 = fe_cnt;
      q.delete();
      build(24'h123456, rand_subs());
      send_beats(10);
      build(24'h0D0282, {56'hDEADBEEFCAFE01, 56'h0badc0ffee0002, 56'h55AA55AA55AA55, 56'h80000000000001});
      send_beats(32);
      idle(4);
      checks++; if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL restart_framing got %0d want %0d", fe_cnt - fe0, 1); end
      checks++; if (q.size() != 1) begin errors++; $display("FAIL restart_count got %0d want 1", q.size()); end
      if (q.size() >= 1) begin
         checks++; if (q[0].h !== 24'h0D0282 || q[0].s !== exp_s) begin errors++; $display("FAIL restart_data got %h/%h want 0d0282/%h", q[0].h, q[0].s, exp_s); end
         checks++; if (q[0].err !== 5'd0) begin errors++; $display("FAIL restart_ecc got %b want 00000", q[0].err); end
      end
      fe0 = fe_cnt;
      build(24'h654321, rand_subs());
      send_beats(20);
      idle(4);
      checks++; if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL drop_framing got %0d want 1", fe_cnt - fe0); end
      checks++; if (q.size() != 1) begin errors++; $display("FAIL drop_count got %0d want 1", q.size()); end
      checks++; if (u_if.header !== 24'h0D0282) begin errors++; $display("FAIL drop_held_header got %h want 0d0282", u_if.header); end
      fe0 = fe_cnt;
      repeat (40) begin
         @(negedge clk);
         u_if.enable       = 1'b1;
         u_if.packet_start = 1'b0;
         u_if.packet_data  = 9'h1FF;
      end
      idle(4);
      checks++; if (q.size() != 1 || fe_cnt != fe0) begin errors++; $display("FAIL idle_no_start got %0d pkts %0d frames want 1 pkt 0 frames", q.size(), fe_cnt - fe0); end
   endtask

   task automatic test_reset_mid();
      int fe0;
      fe0 = fe_cnt;
      q.delete();
      build(24'h0D0282, rand_subs());
      send_beats(15);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (u_if.header !== 24'd0) begin errors++; $display("FAIL async_header got %h want 0", u_if.header); end
      checks++; if (u_if.sub[1] !== 56'd0 || u_if.sub[3] !== 56'd0) begin errors++; $display("FAIL async_sub got %h/%h want 0", u_if.sub[1], u_if.sub[3]); end
      idle(3);
      @(negedge clk);
      rst = 1'b0;
      idle(3);
      checks++; if (q.size() != 0 || fe_cnt != fe0) begin errors++; $display("FAIL reset_abort got %0d pkts %0d frames want 0/0", q.size(), fe_cnt - fe0); end
      build(24'h0D0282, rand_subs());
      send_beats(32);
      idle(4);
      checks++; if (q.size() != 1) begin errors++; $display("FAIL post_reset_count got %0d want 1", q.size()); end
      if (q.size() >= 1) begin
         checks++; if (q[0].h !== exp_h || q[0].s !== exp_s) begin errors++; $display("FAIL post_reset_data got %h/%h want %h/%h", q[0].h, q[0].s, exp_h, exp_s); end
         checks++; if (q[0].err !== 5'd0) begin errors++; $display("FAIL post_reset_ecc got %b want 00000", q[0].err); end
      end
   endtask

   initial begin
      u_if.enable       = 1'b0;
      u_if.packet_start = 1'b0;
      u_if.packet_data  = 9'd0;
      test_reset();
      test_null();
      test_back_to_back();
      test_ecc_single();
      test_ecc_double();
      test_framing();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
